// File: rtl/recepcao_medida_pkg.sv
// Shared definitions for the measurement frame receiver.
// Holds the parser state codes (also shown on db_estado), the ASCII
// delimiters of the "TTTT,UUUU#" frame, the hex digit ranges, and two
// helper functions that classify and decode a hex digit byte.
package recepcao_medida_pkg;

    typedef enum logic [3:0] {
        ESPERA = 4'h0,
        TEMP   = 4'h1,
        SEP    = 4'h2,
        UMID   = 4'h3,
        FIM    = 4'h4,
        ERRO   = 4'hE
    } estado_t;

    localparam logic [7:0] ASCII_VIRGULA   = 8'h2C;  // ','
    localparam logic [7:0] ASCII_CERQUILHA = 8'h23;  // '#'
    localparam logic [7:0] ASCII_0         = 8'h30;
    localparam logic [7:0] ASCII_9         = 8'h39;
    localparam logic [7:0] ASCII_A         = 8'h41;
    localparam logic [7:0] ASCII_F         = 8'h46;

    // Only '0'-'9' and uppercase 'A'-'F' count as digits.
    function automatic logic is_hex(input logic [7:0] b);
        return ((b >= ASCII_0) && (b <= ASCII_9)) ||
               ((b >= ASCII_A) && (b <= ASCII_F));
    endfunction

    // Nibble value of a byte already known to be a hex digit.
    function automatic logic [3:0] hex_val(input logic [7:0] b);
        logic [7:0] d;
        if (b <= ASCII_9)
            d = b - ASCII_0;
        else
            d = b - 8'h37;   // 'A' (0x41) maps to 0xA
        return d[3:0];
    endfunction

endpackage

// File: rtl/recepcao_medida_rx.sv
// rx_serial_8N1: 8N1 asynchronous serial byte receiver.
// The line is first passed through a 2-flop synchronizer (reset to the idle
// level 1). A synchronized falling edge starts a half-bit wait; a line that
// is high again at that point is a false start. Data bits (LSB first) and
// the stop bit are then sampled every DIV cycles.
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous, active-high
//   rx         - raw serial line, idle high
//   dado       - last received byte (valid with byte_valid)
//   byte_valid - one-cycle pulse, stop bit was 1
//   byte_err   - one-cycle pulse, stop bit was 0 (byte dropped)
module rx_serial_8N1 #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] dado,
    output logic       byte_valid,
    output logic       byte_err
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV + 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_estado_t;

    rx_estado_t       state, state_n;
    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       dado_n;
    logic             byte_valid_n, byte_err_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            dado       <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shift      <= shift_n;
            dado       <= dado_n;
            byte_valid <= byte_valid_n;
            byte_err   <= byte_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt + CNT_W'(1);
        bit_idx_n    = bit_idx;
        shift_n      = shift;
        dado_n       = dado;
        byte_valid_n = 1'b0;
        byte_err_n   = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (rx_prev && !rx_sync)
                    state_n = RX_START;
            end
            RX_START: begin
                // Middle of the start bit: still low means a real start.
                if (cnt == CNT_W'(HALF - 1)) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == CNT_W'(DIV - 1)) begin
                    cnt_n   = '0;
                    shift_n = {rx_sync, shift[7:1]};
                    if (bit_idx == 3'd7)
                        state_n = RX_STOP;
                    else
                        bit_idx_n = bit_idx + 3'd1;
                end
            end
            RX_STOP: begin
                if (cnt == CNT_W'(DIV - 1)) begin
                    cnt_n   = '0;
                    state_n = RX_IDLE;
                    if (rx_sync) begin
                        byte_valid_n = 1'b1;
                        dado_n       = shift;
                    end else begin
                        byte_err_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = RX_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: rtl/recepcao_medida.sv
// recepcao_medida: receives "TTTT,UUUU#" measurement frames over an 8N1
// serial line and publishes the temperature and humidity words.
// Digits are collected into shadow registers; the visible outputs change
// only when a complete, well-formed frame ends with '#'. Any malformed
// frame produces a single-cycle ERRO state and the parser resumes waiting
// for the next frame.
// Ports:
//   clock       - system clock, rising edge
//   reset       - asynchronous, active-high
//   rx_serial   - serial line, idle high
//   temperatura - last valid temperature word
//   umidade     - last valid humidity word
//   pronto      - one-cycle pulse, outputs just updated
//   erro        - one-cycle pulse, frame discarded
//   db_estado   - parser state code for the debug display
module recepcao_medida
    import recepcao_medida_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_serial,
    output logic [15:0] temperatura,
    output logic [15:0] umidade,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado
);

    logic [7:0]  dado;
    logic        byte_valid, byte_err;

    estado_t     state, state_n;
    logic [1:0]  count, count_n;
    logic [15:0] temp_sh, temp_sh_n;
    logic [15:0] umid_sh, umid_sh_n;
    logic [15:0] temperatura_n, umidade_n;
    logic        pronto_n;
    logic        digito;
    logic [3:0]  nib;

    rx_serial_8N1 #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx_serial),
        .dado       (dado),
        .byte_valid (byte_valid),
        .byte_err   (byte_err)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ESPERA;
            count       <= '0;
            temp_sh     <= '0;
            umid_sh     <= '0;
            temperatura <= '0;
            umidade     <= '0;
            pronto      <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            temp_sh     <= temp_sh_n;
            umid_sh     <= umid_sh_n;
            temperatura <= temperatura_n;
            umidade     <= umidade_n;
            pronto      <= pronto_n;
        end
    end

    // ERRO is entered for exactly one cycle, so the pulse follows the state.
    assign erro      = (state == ERRO);
    assign db_estado = state;

    always_comb begin
        state_n       = state;
        count_n       = count;
        temp_sh_n     = temp_sh;
        umid_sh_n     = umid_sh;
        temperatura_n = temperatura;
        umidade_n     = umidade;
        pronto_n      = 1'b0;
        digito        = is_hex(dado);
        nib           = hex_val(dado);
        case (state)
            ESPERA: begin
                // A stray '#' here is the tail of a broken frame: ignore it.
                if (byte_valid) begin
                    if (digito) begin
                        temp_sh_n = {12'h000, nib};
                        count_n   = 2'd1;
                        state_n   = TEMP;
                    end else if (dado != ASCII_CERQUILHA) begin
                        state_n = ERRO;
                    end
                end
            end
            TEMP: begin
                if (byte_err) begin
                    state_n = ERRO;
                end else if (byte_valid) begin
                    if (digito) begin
                        temp_sh_n = {temp_sh[11:0], nib};
                        if (count == 2'd3) begin
                            count_n = '0;
                            state_n = SEP;
                        end else begin
                            count_n = count + 2'd1;
                        end
                    end else begin
                        state_n = ERRO;
                    end
                end
            end
            SEP: begin
                if (byte_err) begin
                    state_n = ERRO;
                end else if (byte_valid) begin
                    if (dado == ASCII_VIRGULA) begin
                        count_n = '0;
                        state_n = UMID;
                    end else begin
                        state_n = ERRO;
                    end
                end
            end
            UMID: begin
                if (byte_err) begin
                    state_n = ERRO;
                end else if (byte_valid) begin
                    if (digito) begin
                        umid_sh_n = {umid_sh[11:0], nib};
                        if (count == 2'd3) begin
                            count_n = '0;
                            state_n = FIM;
                        end else begin
                            count_n = count + 2'd1;
                        end
                    end else begin
                        state_n = ERRO;
                    end
                end
            end
            FIM: begin
                if (byte_err) begin
                    state_n = ERRO;
                end else if (byte_valid) begin
                    if (dado == ASCII_CERQUILHA) begin
                        temperatura_n = temp_sh;
                        umidade_n     = umid_sh;
                        pronto_n      = 1'b1;
                        state_n       = ESPERA;
                    end else begin
                        state_n = ERRO;
                    end
                end
            end
            ERRO: begin
                count_n = '0;
                state_n = ESPERA;
            end
            default: begin
                count_n = '0;
                state_n = ESPERA;
            end
        endcase
    end

endmodule

// File: tb/tb_recepcao_medida.sv
module tb_recepcao_medida;

    // 1_950_000 / 115200 = 16.93, truncated to 16 cycles per bit.
    localparam int CLK_FREQ = 1_950_000;
    localparam int BAUD     = 115200;
    localparam int BIT_CYC  = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_serial = 1'b1;
    logic [15:0] temperatura, umidade;
    logic        pronto, erro;
    logic [3:0]  db_estado;

    int checks = 0;
    int errors = 0;
    int n_pronto = 0;
    int n_erro = 0;
    int n_both = 0;
    int p0, e0;

    recepcao_medida #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_serial   (rx_serial),
        .temperatura (temperatura),
        .umidade     (umidade),
        .pronto      (pronto),
        .erro        (erro),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (pronto) n_pronto++;
        if (erro) n_erro++;
        if (pronto && erro) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clock);
        rx_serial = 1'b0;
        repeat (BIT_CYC) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (BIT_CYC) @(negedge clock);
        end
        rx_serial = stop_bit;
        repeat (BIT_CYC) @(negedge clock);
        rx_serial = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], 1'b1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check("rst_temp", 32'(temperatura), 32'h0);
        check("rst_umid", 32'(umidade), 32'h0);
        check("rst_pronto", 32'(pronto), 32'h0);
        check("rst_erro", 32'(erro), 32'h0);
        check("rst_estado", 32'(db_estado), 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Good frame, tracking parser states
        p0 = n_pronto; e0 = n_erro;
        send_str("01");
        check("st_temp", 32'(db_estado), 32'h1);
        send_str("2A");
        check("st_sep", 32'(db_estado), 32'h2);
        send_str(",");
        check("st_umid", 32'(db_estado), 32'h3);
        send_str("0037");
        check("st_fim", 32'(db_estado), 32'h4);
        check("partial_temp", 32'(temperatura), 32'h0);
        send_str("#");
        check("f1_temp", 32'(temperatura), 32'h012A);
        check("f1_umid", 32'(umidade), 32'h0037);
        check("f1_pronto", 32'(n_pronto - p0), 32'd1);
        check("f1_erro", 32'(n_erro - e0), 32'd0);
        check("f1_estado", 32'(db_estado), 32'h0);

        // Invalid digit 'G'
        p0 = n_pronto; e0 = n_erro;
        send_str("01G");
        check("g_erro", 32'(n_erro - e0), 32'd1);
        check("g_estado", 32'(db_estado), 32'h0);
        send_str("2,0000#");
        check("g_pronto", 32'(n_pronto - p0), 32'd0);
        check("g_temp", 32'(temperatura), 32'h012A);
        check("g_umid", 32'(umidade), 32'h0037);
        check("g_resync", 32'(db_estado), 32'h0);

        // Frame after error is accepted
        p0 = n_pronto;
        send_str("FFFF,0001#");
        check("f2_temp", 32'(temperatura), 32'hFFFF);
        check("f2_umid", 32'(umidade), 32'h0001);
        check("f2_pronto", 32'(n_pronto - p0), 32'd1);

        // Lowercase hex is invalid
        p0 = n_pronto; e0 = n_erro;
        send_str("a");
        check("lc_erro", 32'(n_erro - e0), 32'd1);
        send_str("bcd,0001#");
        check("lc_pronto", 32'(n_pronto - p0), 32'd0);
        check("lc_temp", 32'(temperatura), 32'hFFFF);
        check("lc_umid", 32'(umidade), 32'h0001);
        check("lc_estado", 32'(db_estado), 32'h0);

        // Framing error on the separator
        p0 = n_pronto;
        send_str("012A");
        e0 = n_erro;
        send_byte(8'h2C, 1'b0);
        check("stop_erro", 32'(n_erro - e0), 32'd1);
        send_str("0037#");
        check("stop_pronto", 32'(n_pronto - p0), 32'd0);
        check("stop_temp", 32'(temperatura), 32'hFFFF);
        check("stop_umid", 32'(umidade), 32'h0001);

        // Short low glitch while idle (shorter than half a bit)
        p0 = n_pronto; e0 = n_erro;
        @(negedge clock);
        rx_serial = 1'b0;
        repeat (6) @(negedge clock);
        rx_serial = 1'b1;
        repeat (3 * BIT_CYC) @(negedge clock);
        check("glitch_erro", 32'(n_erro - e0), 32'd0);
        check("glitch_pronto", 32'(n_pronto - p0), 32'd0);
        check("glitch_estado", 32'(db_estado), 32'h0);

        // Lone '#' ignored, then digit range boundaries
        e0 = n_erro; p0 = n_pronto;
        send_str("#");
        check("hash_idle_erro", 32'(n_erro - e0), 32'd0);
        send_str("09AF,F09A#");
        check("bnd_temp", 32'(temperatura), 32'h09AF);
        check("bnd_umid", 32'(umidade), 32'hF09A);
        check("bnd_pronto", 32'(n_pronto - p0), 32'd1);
        check("bnd_erro", 32'(n_erro - e0), 32'd0);

        // Reset mid-frame
        send_str("12");
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("mrst_temp", 32'(temperatura), 32'h0);
        check("mrst_umid", 32'(umidade), 32'h0);
        check("mrst_estado", 32'(db_estado), 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        p0 = n_pronto; e0 = n_erro;
        send_str("1234,5678#");
        check("f3_temp", 32'(temperatura), 32'h1234);
        check("f3_umid", 32'(umidade), 32'h5678);
        check("f3_pronto", 32'(n_pronto - p0), 32'd1);
        check("f3_erro", 32'(n_erro - e0), 32'd0);

        check("pronto_erro_overlap", 32'(n_both), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
